// File: rtl/quad_pkg.sv
// Shared encodings for the quadrature decoder: A/B phase states, direction
// values and the up-sequence successor function.
package quad_pkg;

    // State is {A, B}; up order is 00 -> 10 -> 11 -> 01 -> 00.
    typedef enum logic [1:0] {
        S00 = 2'b00,
        S10 = 2'b10,
        S11 = 2'b11,
        S01 = 2'b01
    } quad_state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    function automatic quad_state_t next_up(input quad_state_t state);
        quad_state_t nxt;
        case (state)
            S00:     nxt = S10;
            S10:     nxt = S11;
            S11:     nxt = S01;
            default: nxt = S00;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Encoder phase inputs, control strobes and position outputs of quad_decoder.
interface quad_decoder_if #(
    parameter int CNT_W = 16
);
    logic             a_in;
    logic             b_in;
    logic             en;
    logic             clr;
    logic             err_clr;
    logic [CNT_W-1:0] count;
    logic             dir;
    logic             step;
    logic             err;

    modport master (
        output a_in, b_in, en, clr, err_clr,
        input  count, dir, step, err
    );

    modport slave (
        input  a_in, b_in, en, clr, err_clr,
        output count, dir, step, err
    );
endinterface

// File: rtl/quad_input_filter.sv
// Two-flop synchroniser followed by a stability filter: the filtered output
// only follows the synchronised input after FILT consecutive differing samples.
module quad_input_filter #(
    parameter int FILT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic d_filt
);

    logic [1:0] sync_reg;
    logic [3:0] stab_reg;
    logic       filt_reg;
    logic       sync;

    assign sync   = sync_reg[1];
    assign d_filt = filt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= 2'b00;
            stab_reg <= 4'd0;
            filt_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], d_in};
            // Any return to the filtered level restarts the stability count.
            if (sync == filt_reg) begin
                stab_reg <= 4'd0;
            end else if (stab_reg == 4'(FILT - 1)) begin
                filt_reg <= sync;
                stab_reg <= 4'd0;
            end else begin
                stab_reg <= stab_reg + 4'd1;
            end
        end
    end

endmodule

// File: rtl/quad_decoder.sv
// x4 quadrature decoder: filtered A/B phases drive a wrap-around up/down
// position counter with direction, step pulse and sticky illegal-transition flag.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int FILT  = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    quad_decoder_if.slave  bus
);

    logic [1:0]       raw;
    logic [1:0]       filt;
    quad_state_t      cur;
    quad_state_t      prev_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             dir_reg, dir_next;
    logic             step_reg, step_next;
    logic             err_reg, err_next;
    logic             up_step, dn_step, illegal;

    genvar gi;

    // Index 1 carries phase A, index 0 phase B, matching the {A, B} state order.
    assign raw = {bus.a_in, bus.b_in};

    generate
        for (gi = 0; gi < 2; gi++) begin : g_filt
            quad_input_filter #(.FILT(FILT)) u_filt (
                .clk    (clk),
                .rst_n  (rst_n),
                .d_in   (raw[gi]),
                .d_filt (filt[gi])
            );
        end
    endgenerate

    assign cur = quad_state_t'(filt);

    always_comb begin
        up_step    = 1'b0;
        dn_step    = 1'b0;
        illegal    = 1'b0;
        count_next = count_reg;
        dir_next   = dir_reg;
        step_next  = 1'b0;
        err_next   = err_reg;

        if (cur != prev_reg) begin
            if (cur == next_up(prev_reg)) begin
                up_step = 1'b1;
            end else if (prev_reg == next_up(cur)) begin
                dn_step = 1'b1;
            end else begin
                illegal = 1'b1;
            end
        end

        // A new illegal transition outranks a simultaneous clear request.
        if (illegal) begin
            err_next = 1'b1;
        end else if (bus.err_clr) begin
            err_next = 1'b0;
        end

        if (bus.clr) begin
            count_next = '0;
        end else if (bus.en && (up_step || dn_step)) begin
            count_next = up_step ? count_reg + CNT_W'(1) : count_reg - CNT_W'(1);
            dir_next   = up_step ? DIR_UP : DIR_DN;
            step_next  = 1'b1;
        end
    end

    // prev follows cur even while disabled so re-enabling cannot emit a stale step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_reg  <= S00;
            count_reg <= '0;
            dir_reg   <= 1'b0;
            step_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            prev_reg  <= cur;
            count_reg <= count_next;
            dir_reg   <= dir_next;
            step_reg  <= step_next;
            err_reg   <= err_next;
        end
    end

    assign bus.count = count_reg;
    assign bus.dir   = dir_reg;
    assign bus.step  = step_reg;
    assign bus.err   = err_reg;

endmodule
